soc_event_bridge_tx: RTL and testbench



---
 rtl/soc_event_bridge_pkg.sv | 24 ++
 rtl/soc_event_bridge_tx_if.sv | 30 +++
 rtl/cdc_sync_cell.sv | 30 +++
 rtl/soc_event_rr_arb.sv | 41 ++++
 rtl/soc_event_bridge_tx.sv | 154 +++++++++++++++
 tb/tb_soc_event_bridge_tx.sv | 317 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/soc_event_bridge_pkg.sv
// ============================================================================
//  Module      : soc_event_bridge_pkg
//  Description : Shared types, constants and helpers for the SoC-to-cluster
//                token-based event bridge (source side).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package soc_event_bridge_pkg;

    localparam int EVT_ID_W   = 8;
    localparam int LOST_CNT_W = 16;

    typedef logic [EVT_ID_W-1:0] evt_id_t;

    // Round-robin pointer after a grant: the channel just served drops to
    // lowest priority.
    function automatic int rr_next_ptr(input int gnt_idx, input int nb);
        return (gnt_idx + 1 >= nb) ? 0 : gnt_idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/soc_event_bridge_tx_if.sv
// ============================================================================
//  Module      : soc_event_bridge_tx_if
//  Description : Token/pointer/data bus between the bridge producer (SoC
//                side) and the cluster event unit consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface soc_event_bridge_tx_if #(
    parameter int DEPTH      = 8,
    parameter int EVNT_WIDTH = 8
);
    logic [DEPTH-1:0]            events_wt_o;
    logic [DEPTH-1:0]            events_rp_i;
    logic [DEPTH*EVNT_WIDTH-1:0] events_da_o;

    modport master (
        output events_wt_o,
        output events_da_o,
        input  events_rp_i
    );

    modport slave (
        input  events_wt_o,
        input  events_da_o,
        output events_rp_i
    );
endinterface

`default_nettype wire

// File: rtl/cdc_sync_cell.sv
// ============================================================================
//  Module      : cdc_sync_cell
//  Description : Single-bit multi-flop synchronizer, asynchronous reset to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdc_sync_cell #(
    parameter int STAGES = 2
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic d_i,
    output logic      q_o
);
    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain[STAGES-1];
endmodule

`default_nettype wire

// File: rtl/soc_event_rr_arb.sv
// ============================================================================
//  Module      : soc_event_rr_arb
//  Description : Combinational round-robin arbiter. Searches upward from the
//                priority pointer and returns a one-hot grant and its index.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module soc_event_rr_arb #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  wire logic [N-1:0]     req,
    input  wire logic [IDX_W-1:0] ptr,
    input  wire logic             en,
    output logic [N-1:0]          gnt,
    output logic [IDX_W-1:0]      gnt_idx,
    output logic                  gnt_valid
);
    function automatic int wrap_idx(input int base, input int offs);
        return (base + offs) % N;
    endfunction

    // First requester at or after the pointer wins; nothing when disabled.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                if (!gnt_valid && req[wrap_idx(int'(ptr), k)]) begin
                    gnt_valid                     = 1'b1;
                    gnt[wrap_idx(int'(ptr), k)]   = 1'b1;
                    gnt_idx                       = IDX_W'(wrap_idx(int'(ptr), k));
                end
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/soc_event_bridge_tx.sv
// ============================================================================
//  Module      : soc_event_bridge_tx
//  Description : Source side of the SoC-to-cluster event bridge. Latches one
//                pending event per channel, arbitrates round-robin and writes
//                the winner into a DEPTH-slot toggle-token buffer.
//                Optional feature macro: SOC_EVENT_BRIDGE_LOST_CNT_EN enables
//                the saturating dropped-event counter on lost_cnt_o.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module soc_event_bridge_tx
    import soc_event_bridge_pkg::*;
#(
    parameter int NB_CHANNELS = 4,
    parameter int EVNT_WIDTH  = 8,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic                              clk_i,
    input  wire logic                              rst_i,
    input  wire logic [NB_CHANNELS-1:0]            evt_valid_i,
    input  wire logic [NB_CHANNELS*EVNT_WIDTH-1:0] evt_data_i,
    soc_event_bridge_tx_if.master                  bus,
    output logic [NB_CHANNELS-1:0]                 pending_o,
    output logic                                   full_o,
    output logic                                   lost_o,
    output logic [LOST_CNT_W-1:0]                  lost_cnt_o
);
    localparam int PTR_W  = $clog2(NB_CHANNELS);
    localparam int WIDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]                       wt;
    logic [DEPTH-1:0][EVNT_WIDTH-1:0]       da;
    logic [DEPTH-1:0]                       rp_sync;
    logic [NB_CHANNELS-1:0]                 pend;
    logic [NB_CHANNELS-1:0][EVNT_WIDTH-1:0] ids;
    logic [PTR_W-1:0]                       ptr;
    logic [WIDX_W-1:0]                      widx;
    logic                                   lost;

    logic                                   full;
    logic [NB_CHANNELS-1:0]                 gnt;
    logic [PTR_W-1:0]                       gnt_idx;
    logic                                   gnt_valid;
    logic [NB_CHANNELS-1:0]                 loss;

    // Consumer read pointer crosses in bit by bit; each bit is a toggle so
    // per-bit synchronization is safe.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_rp_sync
            cdc_sync_cell #(.STAGES(SYNC_STAGES)) u_sync (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .d_i   (bus.events_rp_i[i]),
                .q_o   (rp_sync[i])
            );
        end
    endgenerate

    assign full = (wt[widx] != rp_sync[widx]);

    soc_event_rr_arb #(.N(NB_CHANNELS), .IDX_W(PTR_W)) u_arb (
        .req       (pend),
        .ptr       (ptr),
        .en        (!full),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // A pulse onto an already-pending channel is dropped unless that channel
    // is being drained this very cycle.
    assign loss = evt_valid_i & pend & ~gnt;

    // Buffer write: data and token move together, then the index advances.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wt   <= '0;
            da   <= '0;
            widx <= '0;
            ptr  <= '0;
        end else if (gnt_valid) begin
            da[widx] <= ids[gnt_idx];
            wt[widx] <= ~wt[widx];
            widx     <= (widx == WIDX_W'(DEPTH - 1)) ? '0 : widx + 1'b1;
            ptr      <= PTR_W'(rr_next_ptr(int'(gnt_idx), NB_CHANNELS));
        end
    end

    // Pending latches: first event wins, a new pulse beats a same-cycle clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend <= '0;
            ids  <= '0;
        end else begin
            for (int c = 0; c < NB_CHANNELS; c++) begin
                if (evt_valid_i[c]) begin
                    pend[c] <= 1'b1;
                    if (!pend[c] || gnt[c]) begin
                        ids[c] <= evt_data_i[c*EVNT_WIDTH +: EVNT_WIDTH];
                    end
                end else if (gnt[c]) begin
                    pend[c] <= 1'b0;
                end
            end
        end
    end

    // Registered loss pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lost <= 1'b0;
        end else begin
            lost <= |loss;
        end
    end

`ifdef SOC_EVENT_BRIDGE_LOST_CNT_EN
    localparam int SUM_W = LOST_CNT_W + 1;

    logic [LOST_CNT_W-1:0] lost_cnt;
    logic [SUM_W-1:0]      lost_sum;

    // Add every channel that lost an event this cycle; carry-out means overflow.
    always_comb begin
        lost_sum = {1'b0, lost_cnt};
        for (int c = 0; c < NB_CHANNELS; c++) begin
            lost_sum = lost_sum + SUM_W'(loss[c]);
        end
    end

    // Saturating loss counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lost_cnt <= '0;
        end else begin
            lost_cnt <= lost_sum[LOST_CNT_W] ? '1 : lost_sum[LOST_CNT_W-1:0];
        end
    end

    assign lost_cnt_o = lost_cnt;
`else
    assign lost_cnt_o = '0;
`endif

    assign bus.events_wt_o = wt;
    assign bus.events_da_o = da;
    assign pending_o       = pend;
    assign full_o          = full;
    assign lost_o          = lost;
endmodule

`default_nettype wire

// File: tb/tb_soc_event_bridge_tx.sv
// ============================================================================
//  Module      : tb_soc_event_bridge_tx
//  Description : Self-checking bench for soc_event_bridge_tx with a
//                behavioural reference model of the slot protocol.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_soc_event_bridge_tx;
    import soc_event_bridge_pkg::*;

    localparam int NB = 4;
    localparam int W  = 8;
    localparam int D  = 8;
    localparam int S  = 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NB-1:0]     evt_valid_i;
    logic [NB*W-1:0]   evt_data_i;
    logic [NB-1:0]     pending_o;
    logic              full_o;
    logic              lost_o;
    logic [15:0]       lost_cnt_o;

    soc_event_bridge_tx_if #(.DEPTH(D), .EVNT_WIDTH(W)) bus ();

    soc_event_bridge_tx #(
        .NB_CHANNELS (NB),
        .EVNT_WIDTH  (W),
        .DEPTH       (D),
        .SYNC_STAGES (S)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .evt_valid_i (evt_valid_i),
        .evt_data_i  (evt_data_i),
        .bus         (bus.master),
        .pending_o   (pending_o),
        .full_o      (full_o),
        .lost_o      (lost_o),
        .lost_cnt_o  (lost_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [D-1:0]   m_wt;
    logic [D*W-1:0] m_da;
    logic [NB-1:0]  m_pend;
    evt_id_t        m_id [NB];
    int             m_ptr;
    int             m_widx;
    logic [D-1:0]   m_sync [S];
    logic           m_full;
    logic           m_lost;
    logic [15:0]    m_lcnt;
    int             c_ridx;

    function automatic void model_reset();
        m_wt = '0; m_da = '0; m_pend = '0; m_ptr = 0; m_widx = 0;
        m_full = 1'b0; m_lost = 1'b0; m_lcnt = '0; c_ridx = 0;
        for (int c = 0; c < NB; c++) m_id[c] = '0;
        for (int s = 0; s < S; s++) m_sync[s] = '0;
    endfunction

    // One clock edge of the bridge, described from the slot/pending rules.
    function automatic void model_edge(input logic [NB-1:0] v, input logic [NB*W-1:0] d,
                                       input logic [D-1:0] rp);
        int g;
        int nl;
        logic [D-1:0] rps;
        g   = -1;
        nl  = 0;
        rps = m_sync[S-1];
        if (m_wt[m_widx] == rps[m_widx]) begin
            for (int k = 0; k < NB; k++)
                if (g < 0 && m_pend[(m_ptr + k) % NB]) g = (m_ptr + k) % NB;
        end
        for (int c = 0; c < NB; c++)
            if (v[c] && m_pend[c] && c != g) nl++;
        if (g >= 0) begin
            m_da[m_widx*W +: W] = m_id[g];
            m_wt[m_widx]        = ~m_wt[m_widx];
            m_widx              = (m_widx + 1) % D;
            m_ptr               = (g + 1) % NB;
            m_pend[g]           = 1'b0;
        end
        for (int c = 0; c < NB; c++) begin
            if (v[c] && !m_pend[c]) begin
                m_pend[c] = 1'b1;
                m_id[c]   = d[c*W +: W];
            end
        end
        m_lost = (nl > 0);
`ifdef SOC_EVENT_BRIDGE_LOST_CNT_EN
        m_lcnt = (int'(m_lcnt) + nl > 65535) ? 16'hFFFF : 16'(int'(m_lcnt) + nl);
`endif
        for (int s = S - 1; s > 0; s--) m_sync[s] = m_sync[s-1];
        m_sync[0] = rp;
        m_full = (m_wt[m_widx] != m_sync[S-1][m_widx]);
    endfunction

    // Drive one cycle of stimulus (with optional in-order consumer), step
    // the model at the edge and leave time 1 unit past the edge.
    task automatic cycle(input logic [NB-1:0] v, input logic [NB*W-1:0] d,
                         input bit drain, input logic [D-1:0] rp_flip);
        logic [D-1:0] rp;
        rp = bus.events_rp_i;
        if (drain && (bus.events_wt_o[c_ridx] != rp[c_ridx])) begin
            rp[c_ridx] = ~rp[c_ridx];
            c_ridx     = (c_ridx + 1) % D;
        end
        rp              = rp ^ rp_flip;
        bus.events_rp_i = rp;
        evt_valid_i     = v;
        evt_data_i      = d;
        @(posedge clk_i);
        model_edge(v, d, rp);
        #1;
        evt_valid_i = '0;
    endtask

    task automatic do_reset();
        rst_i           = 1'b1;
        evt_valid_i     = '0;
        evt_data_i      = '0;
        bus.events_rp_i = '0;
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (bus.events_wt_o !== '0) begin n_err++; $display("FAIL reset_wt: got %h want 0", bus.events_wt_o); end
        n_vec++; if (bus.events_da_o !== '0) begin n_err++; $display("FAIL reset_da: got %h want 0", bus.events_da_o); end
        n_vec++; if (pending_o !== '0) begin n_err++; $display("FAIL reset_pending: got %h want 0", pending_o); end
        n_vec++; if (full_o !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full_o); end
        n_vec++; if (lost_o !== 1'b0) begin n_err++; $display("FAIL reset_lost: got %b want 0", lost_o); end
        n_vec++; if (lost_cnt_o !== '0) begin n_err++; $display("FAIL reset_lost_cnt: got %h want 0", lost_cnt_o); end
    endtask

    task automatic test_single_event();
        do_reset();
        cycle(4'b0100, 32'h005A_0000, 1'b0, '0);
        n_vec++; if (pending_o !== 4'b0100) begin n_err++; $display("FAIL single_pend1: got %b want 0100", pending_o); end
        n_vec++; if (bus.events_wt_o !== 8'h00) begin n_err++; $display("FAIL single_wt1: got %h want 00", bus.events_wt_o); end
        cycle('0, '0, 1'b0, '0);
        n_vec++; if (bus.events_wt_o !== 8'h01) begin n_err++; $display("FAIL single_wt2: got %h want 01", bus.events_wt_o); end
        n_vec++; if (bus.events_da_o[7:0] !== 8'h5A) begin n_err++; $display("FAIL single_da0: got %h want 5a", bus.events_da_o[7:0]); end
        n_vec++; if (pending_o !== 4'b0000) begin n_err++; $display("FAIL single_pend2: got %b want 0000", pending_o); end
    endtask

    task automatic test_round_robin();
        do_reset();
        cycle(4'hF, 32'h1312_1110, 1'b0, '0);
        for (int k = 0; k < 4; k++) begin
            cycle('0, '0, 1'b0, '0);
            n_vec++;
            if (bus.events_wt_o !== 8'((2 << k) - 1)) begin
                n_err++; $display("FAIL rr_wt[%0d]: got %h want %h", k, bus.events_wt_o, 8'((2 << k) - 1));
            end
            n_vec++;
            if (bus.events_da_o[k*W +: W] !== 8'(8'h10 + k)) begin
                n_err++; $display("FAIL rr_slot[%0d]: got %h want %h", k, bus.events_da_o[k*W +: W], 8'(8'h10 + k));
            end
        end
        n_vec++; if (pending_o !== '0) begin n_err++; $display("FAIL rr_pend: got %b want 0", pending_o); end
    endtask

    task automatic test_full();
        logic [NB*W-1:0] d;
        do_reset();
        for (int e = 0; e < 10; e++) begin
            d = (32'h20 + 32'(e)) << 8;
            cycle(4'b0010, d, 1'b0, '0);
            if (e == 9) begin
                n_vec++; if (lost_o !== 1'b1) begin n_err++; $display("FAIL full_lost: got %b want 1", lost_o); end
                n_vec++; if (pending_o !== 4'b0010) begin n_err++; $display("FAIL full_pend: got %b want 0010", pending_o); end
            end
            cycle('0, '0, 1'b0, '0);
            n_vec++; if (bus.events_wt_o !== m_wt) begin n_err++; $display("FAIL full_wt_model: got %h want %h", bus.events_wt_o, m_wt); end
            n_vec++; if (full_o !== m_full) begin n_err++; $display("FAIL full_flag_model: got %b want %b", full_o, m_full); end
            if (e == 7) begin
                n_vec++; if (full_o !== 1'b1) begin n_err++; $display("FAIL full_after8: got %b want 1", full_o); end
            end
        end
        for (int k = 0; k < 3; k++) begin
            cycle('0, '0, 1'b0, (k == 0) ? 8'h01 : 8'h00);
            if (k == 1) begin
                n_vec++; if (bus.events_wt_o !== 8'hFF) begin n_err++; $display("FAIL full_wait_wt: got %h want ff", bus.events_wt_o); end
            end
        end
        n_vec++; if (bus.events_wt_o !== 8'hFE) begin n_err++; $display("FAIL full_refill_wt: got %h want fe", bus.events_wt_o); end
        n_vec++; if (bus.events_da_o[7:0] !== 8'h28) begin n_err++; $display("FAIL full_refill_da: got %h want 28", bus.events_da_o[7:0]); end
        n_vec++; if (pending_o !== '0) begin n_err++; $display("FAIL full_refill_pend: got %b want 0", pending_o); end
    endtask

    task automatic test_wraparound();
        int tog [D];
        logic [D-1:0] prev;
        int gap;
        int ch;
        for (int i = 0; i < D; i++) tog[i] = 0;
        do_reset();
        prev = '0;
        for (int n = 0; n < 20 + 12; n++) begin
            if (n < 20) begin
                ch = $urandom_range(0, NB - 1);
                cycle(4'(1 << ch), (32'h40 + 32'(n)) << (ch * W), 1'b1, '0);
                gap = $urandom_range(0, 2);
            end else begin
                cycle('0, '0, 1'b1, '0);
                gap = 0;
            end
            for (int g = 0; g <= gap; g++) begin
                if (g > 0) cycle('0, '0, 1'b1, '0);
                for (int i = 0; i < D; i++) if (bus.events_wt_o[i] != prev[i]) tog[i]++;
                prev = bus.events_wt_o;
                n_vec++; if (lost_o !== 1'b0) begin n_err++; $display("FAIL wrap_lost: got %b want 0", lost_o); end
                n_vec++; if (bus.events_da_o !== m_da) begin n_err++; $display("FAIL wrap_da: got %h want %h", bus.events_da_o, m_da); end
                n_vec++; if (pending_o !== m_pend) begin n_err++; $display("FAIL wrap_pend: got %b want %b", pending_o, m_pend); end
            end
        end
        n_vec++; if (bus.events_wt_o !== 8'h0F) begin n_err++; $display("FAIL wrap_wt_final: got %h want 0f", bus.events_wt_o); end
        for (int i = 0; i < D; i++) begin
            n_vec++;
            if (tog[i] != ((i < 4) ? 3 : 2)) begin
                n_err++; $display("FAIL wrap_toggles[%0d]: got %0d want %0d", i, tog[i], (i < 4) ? 3 : 2);
            end
        end
    endtask

    task automatic test_set_grant();
        do_reset();
        cycle(4'b0010, 32'h0000_AA00, 1'b0, '0);
        cycle(4'b0010, 32'h0000_BB00, 1'b0, '0);
        n_vec++; if (bus.events_da_o[7:0] !== 8'hAA) begin n_err++; $display("FAIL setgnt_da0: got %h want aa", bus.events_da_o[7:0]); end
        n_vec++; if (pending_o !== 4'b0010) begin n_err++; $display("FAIL setgnt_pend: got %b want 0010", pending_o); end
        n_vec++; if (lost_o !== 1'b0) begin n_err++; $display("FAIL setgnt_lost: got %b want 0", lost_o); end
        cycle('0, '0, 1'b0, '0);
        n_vec++; if (bus.events_da_o[15:8] !== 8'hBB) begin n_err++; $display("FAIL setgnt_da1: got %h want bb", bus.events_da_o[15:8]); end
        n_vec++; if (bus.events_wt_o !== 8'h03) begin n_err++; $display("FAIL setgnt_wt: got %h want 03", bus.events_wt_o); end
    endtask

    task automatic test_random();
        logic [NB-1:0] v;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'($urandom_range(0, 1) << $urandom_range(0, 3));
            cycle(v, $urandom, ($urandom_range(0, 2) != 0), '0);
            n_vec++; if (bus.events_wt_o !== m_wt) begin n_err++; $display("FAIL rand_wt: got %h want %h", bus.events_wt_o, m_wt); end
            n_vec++; if (bus.events_da_o !== m_da) begin n_err++; $display("FAIL rand_da: got %h want %h", bus.events_da_o, m_da); end
            n_vec++; if (pending_o !== m_pend) begin n_err++; $display("FAIL rand_pend: got %b want %b", pending_o, m_pend); end
            n_vec++; if (full_o !== m_full) begin n_err++; $display("FAIL rand_full: got %b want %b", full_o, m_full); end
            n_vec++; if (lost_o !== m_lost) begin n_err++; $display("FAIL rand_lost: got %b want %b", lost_o, m_lost); end
            n_vec++; if (lost_cnt_o !== m_lcnt) begin n_err++; $display("FAIL rand_lost_cnt: got %h want %h", lost_cnt_o, m_lcnt); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(4'hF, 32'h3322_1100, 1'b0, '0);
        cycle('0, '0, 1'b0, '0);
        n_vec++; if (pending_o !== 4'b1110) begin n_err++; $display("FAIL mid_pend_before: got %b want 1110", pending_o); end
        rst_i           = 1'b1;
        bus.events_rp_i = '0;
        model_reset();
        #1;
        n_vec++; if (bus.events_wt_o !== '0) begin n_err++; $display("FAIL mid_wt: got %h want 0", bus.events_wt_o); end
        n_vec++; if (bus.events_da_o !== '0) begin n_err++; $display("FAIL mid_da: got %h want 0", bus.events_da_o); end
        n_vec++; if (pending_o !== '0) begin n_err++; $display("FAIL mid_pend: got %b want 0", pending_o); end
        n_vec++; if (full_o !== 1'b0) begin n_err++; $display("FAIL mid_full: got %b want 0", full_o); end
        n_vec++; if (lost_o !== 1'b0) begin n_err++; $display("FAIL mid_lost: got %b want 0", lost_o); end
        n_vec++; if (lost_cnt_o !== '0) begin n_err++; $display("FAIL mid_lost_cnt: got %h want 0", lost_cnt_o); end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

`ifdef SOC_EVENT_BRIDGE_LOST_CNT_EN
    task automatic test_lost_saturate();
        do_reset();
        for (int n = 0; n < 16600; n++) begin
            cycle(4'hF, $urandom, 1'b0, '0);
            if (n == 50 || n == 5000) begin
                n_vec++; if (lost_cnt_o !== m_lcnt) begin n_err++; $display("FAIL sat_cnt_mid: got %h want %h", lost_cnt_o, m_lcnt); end
            end
        end
        n_vec++; if (lost_cnt_o !== 16'hFFFF) begin n_err++; $display("FAIL sat_cnt: got %h want ffff", lost_cnt_o); end
        n_vec++; if (lost_o !== 1'b1) begin n_err++; $display("FAIL sat_lost: got %b want 1", lost_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_event();
        test_round_robin();
        test_full();
        test_wraparound();
        test_set_grant();
        test_random();
        test_reset_mid();
`ifdef SOC_EVENT_BRIDGE_LOST_CNT_EN
        test_lost_saturate();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
